// File: rtl/ascii_pkg.sv
// Shared ASCII-art quantisation: cell geometry, luma, level-to-glyph map and FSM states.
// Used by both the on-screen ASCII filter and the UART text exporter.
package ascii_pkg;

  localparam int CHAR_SIZE = 8;
  localparam int CHARS_X   = 20;
  localparam int CHARS_Y   = 15;
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
    S_WAIT,
    S_FIN
  } tx_state_t;

  // (8R + 16G + 8B) / 4 on the channel MSB-aligned to 8 bits; fits 10 bits before the shift
  function automatic logic [7:0] luma_rgb565(input logic [15:0] px);
    logic [9:0] sum;
    sum = {2'b00, px[15:11], 3'b000} + {1'b0, px[10:5], 3'b000} + {2'b00, px[4:0], 3'b000};
    return 8'(sum >> 2);
  endfunction

  function automatic logic [7:0] level_to_ascii(input logic [2:0] level);
    case (level)
      3'd0:    return 8'h20;
      3'd1:    return 8'h2E;
      3'd2:    return 8'h3A;
      3'd3:    return 8'h2B;
      3'd4:    return 8'h2A;
      3'd5:    return 8'h23;
      3'd6:    return 8'h4D;
      default: return 8'h40;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer: accepts a byte when ready, start bit appears the next cycle.
// ready is low for the whole frame; byte_done pulses the cycle after the stop bit ends.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       byte_done
);

  localparam int BW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  logic          active;
  logic [8:0]    shreg;
  logic [3:0]    bit_cnt;
  logic [BW-1:0] baud_cnt;

  assign ready = !active;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active    <= 1'b0;
      shreg     <= '0;
      bit_cnt   <= '0;
      baud_cnt  <= '0;
      tx        <= 1'b1;
      byte_done <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      if (!active) begin
        if (valid) begin
          active   <= 1'b1;
          tx       <= 1'b0;
          shreg    <= {1'b1, data};
          bit_cnt  <= '0;
          baud_cnt <= '0;
        end
      end else if (baud_cnt == BAUD_LAST) begin
        baud_cnt <= '0;
        // bit 9 is the stop bit; shreg refills with ones so tx idles high
        if (bit_cnt == 4'd9) begin
          active    <= 1'b0;
          byte_done <= 1'b1;
        end else begin
          tx      <= shreg[0];
          shreg   <= {1'b1, shreg[8:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else begin
        baud_cnt <= baud_cnt + BW'(1);
      end
    end
  end

endmodule

// File: rtl/ascii_frame_uart_tx.sv
// Snoops the pixel stream into a 20x15 brightness map and sends it as 15 CR/LF text lines at 8N1.
// Map writes are blocked while busy; start is ignored unless idle or on the done cycle.
module ascii_frame_uart_tx
  import ascii_pkg::*;
#(
  parameter int CHAR_SIZE    = 8,
  parameter int IMG_WIDTH    = 160,
  parameter int IMG_HEIGHT   = 120,
  parameter int CLKS_PER_BIT = 217
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        capture_en,
  input  logic        pixel_valid,
  input  logic [9:0]  x_local,
  input  logic [9:0]  y_local,
  input  logic [15:0] rgb565_in,
  input  logic        start,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int CSH   = $clog2(CHAR_SIZE);
  localparam int MAP_N = CHARS_X * CHARS_Y;
  localparam logic [9:0] X_LIM = 10'(IMG_WIDTH);
  localparam logic [9:0] Y_LIM = 10'(IMG_HEIGHT);

  tx_state_t  state;
  logic [3:0] row;
  logic [4:0] col;
  logic [2:0] cell_map [MAP_N];
  logic [2:0] rd_level;
  logic [2:0] wr_level;
  logic [8:0] wr_addr;
  logic [8:0] rd_addr;
  logic       wr_en;
  logic [7:0] tx_data;
  logic       ser_ready;
  logic       byte_done;

  assign wr_level = 3'(luma_rgb565(rgb565_in) >> 5);
  assign wr_en    = capture_en && pixel_valid && !busy &&
                    (x_local[CSH-1:0] == '0) && (y_local[CSH-1:0] == '0) &&
                    (x_local < X_LIM) && (y_local < Y_LIM);
  assign wr_addr  = 9'(y_local >> CSH) * 9'(CHARS_X) + 9'(x_local >> CSH);
  assign rd_addr  = 9'(row) * 9'(CHARS_X) + 9'(col);

  // Map is deliberately not reset so a frozen picture survives a reset.
  always_ff @(posedge clk) begin
    if (wr_en)
      cell_map[wr_addr] <= wr_level;
    if (state == S_FETCH && col < 5'(CHARS_X))
      rd_level <= cell_map[rd_addr];
  end

  always_comb begin
    tx_data = level_to_ascii(rd_level);
    if (col == 5'(CHARS_X))
      tx_data = CR;
    else if (col == 5'(CHARS_X + 1))
      tx_data = LF;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      row   <= '0;
      col   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_FETCH;
            busy  <= 1'b1;
            row   <= '0;
            col   <= '0;
          end
        end
        S_FETCH: state <= S_SEND;
        S_SEND: begin
          if (ser_ready)
            state <= S_WAIT;
        end
        S_WAIT: begin
          if (byte_done) begin
            if (col == 5'(CHARS_X + 1)) begin
              col <= '0;
              if (row == 4'(CHARS_Y - 1)) begin
                row   <= '0;
                state <= S_FIN;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                row   <= row + 4'd1;
                state <= S_FETCH;
              end
            end else begin
              col   <= col + 5'd1;
              state <= S_FETCH;
            end
          end
        end
        S_FIN: begin
          // a start coinciding with done chains straight into the next frame
          if (start) begin
            state <= S_FETCH;
            busy  <= 1'b1;
            row   <= '0;
            col   <= '0;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
    .clk       (clk),
    .reset     (reset),
    .data      (tx_data),
    .valid     (state == S_SEND),
    .ready     (ser_ready),
    .tx        (tx),
    .byte_done (byte_done)
  );

endmodule

// File: tb/tb_ascii_frame_uart_tx.sv
// Directed bench: decodes the UART line cycle by cycle against hand-computed frame text.
module tb_ascii_frame_uart_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        capture_en = 1'b0;
  logic        pixel_valid = 1'b0;
  logic [9:0]  x_local = '0;
  logic [9:0]  y_local = '0;
  logic [15:0] rgb565_in = '0;
  logic        start = 1'b0;
  logic        tx;
  logic        busy;
  logic        done;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int byte_idx = 0;

  typedef struct {
    logic [15:0] rgb;
    logic [7:0]  exp_ch;
  } vec_t;
  vec_t tbl[20];

  ascii_frame_uart_tx #(.CLKS_PER_BIT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .capture_en  (capture_en),
    .pixel_valid (pixel_valid),
    .x_local     (x_local),
    .y_local     (y_local),
    .rgb565_in   (rgb565_in),
    .start       (start),
    .tx          (tx),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_char(input int mode, input int c);
    if (c == 20) return 8'h0D;
    if (c == 21) return 8'h0A;
    if (mode == 0) return 8'h20;
    if (mode == 1) return 8'h40;
    return tbl[c].exp_ch;
  endfunction

  task automatic poke(input int x, input int y, input logic [15:0] v);
    @(negedge clk);
    pixel_valid = 1'b1;
    x_local = 10'(x);
    y_local = 10'(y);
    rgb565_in = v;
    @(negedge clk);
    pixel_valid = 1'b0;
  endtask

  task automatic load_map(input int mode);
    for (int cy = 0; cy < 15; cy++)
      for (int cx = 0; cx < 20; cx++) begin
        @(negedge clk);
        pixel_valid = 1'b1;
        x_local = 10'(cx * 8);
        y_local = 10'(cy * 8);
        rgb565_in = (mode == 0) ? 16'h0000 : (mode == 1) ? 16'hFFFF : tbl[cx].rgb;
      end
    @(negedge clk);
    pixel_valid = 1'b0;
  endtask

  task automatic start_frame(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check(busy === 1'b1, {tag, " busy after start"}, 64'(busy), 1);
  endtask

  // One byte: at most max_idle high cycles, then 40 samples that must be the exact 4-cycle-per-bit wave.
  task automatic get_byte(input logic [7:0] exp, input int max_idle, input string name);
    int idle;
    bit found;
    logic [39:0] got, want;
    logic [9:0] f;
    idle = 0;
    found = 1'b0;
    got = '0;
    f = {1'b1, exp, 1'b0};
    for (int i = 0; i < 40; i++) want[i] = f[i/4];
    while (!found && idle <= max_idle) begin
      @(negedge clk);
      if (tx === 1'b0) found = 1'b1;
      else idle++;
    end
    check(found, {name, " start gap"}, 64'(idle), 64'(max_idle));
    if (found) begin
      for (int i = 1; i < 40; i++) begin
        @(negedge clk);
        got[i] = tx;
      end
      check(got === want, name, 64'(got), 64'(want));
    end
  endtask

  task automatic recv_frame(input int mode, input int nbytes, input string tag);
    for (int b = 0; b < nbytes; b++) begin
      byte_idx = b;
      get_byte(exp_char(mode, b % 22), 3, $sformatf("%s r%0d c%0d", tag, b / 22, b % 22));
    end
    byte_idx = nbytes;
  endtask

  task automatic finish_frame(input int d0, input string tag, input bit chain);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    check(seen, {tag, " done seen"}, 64'(seen), 1);
    check(busy === 1'b0, {tag, " busy low at done"}, 64'(busy), 0);
    if (chain) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check(done === 1'b0, {tag, " done one cycle"}, 64'(done), 0);
    check(busy === chain, {tag, " busy after done"}, 64'(busy), 64'(chain));
    check(done_cnt - d0 == 1, {tag, " done count"}, 64'(done_cnt - d0), 1);
  endtask

  initial begin
    int lows;
    int d0;
    bit found;
    int idle;

    tbl[0]  = '{16'h0000, 8'h20};  tbl[1]  = '{16'h2104, 8'h2E};
    tbl[2]  = '{16'h4208, 8'h3A};  tbl[3]  = '{16'h630C, 8'h2B};
    tbl[4]  = '{16'h8410, 8'h2A};  tbl[5]  = '{16'hA514, 8'h23};
    tbl[6]  = '{16'hC618, 8'h4D};  tbl[7]  = '{16'hE71C, 8'h40};
    tbl[8]  = '{16'h0841, 8'h20};  tbl[9]  = '{16'h39E7, 8'h2E};
    tbl[10] = '{16'h4A49, 8'h3A};  tbl[11] = '{16'h630C, 8'h2B};
    tbl[12] = '{16'h8410, 8'h2A};  tbl[13] = '{16'hA514, 8'h23};
    tbl[14] = '{16'hC618, 8'h4D};  tbl[15] = '{16'hFFFF, 8'h40};
    tbl[16] = '{16'h0000, 8'h20};  tbl[17] = '{16'hF800, 8'h2E};
    tbl[18] = '{16'h0400, 8'h3A};  tbl[19] = '{16'h07E0, 8'h2B};

    // reset held while inputs toggle
    capture_en = 1'b1;
    start = 1'b1;
    poke(0, 0, 16'hFFFF);
    check(tx === 1'b1, "reset tx", 64'(tx), 1);
    check(busy === 1'b0, "reset busy", 64'(busy), 0);
    check(done === 1'b0, "reset done", 64'(done), 0);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    lows = 0;
    repeat (10000) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
      if (busy !== 1'b0) lows++;
    end
    check(lows == 0, "idle 10k", 64'(lows), 0);

    // frame A: all dark, plus non-origin pixels that must not land in the map
    load_map(0);
    poke(1, 0, 16'hFFFF);
    poke(0, 1, 16'hFFFF);
    poke(7, 7, 16'hFFFF);
    poke(9, 8, 16'hFFFF);
    d0 = done_cnt;
    start_frame("A");
    recv_frame(0, 330, "A");
    finish_frame(d0, "A", 1'b0);

    // frame B: level ramp; bright pixels and a second start arrive while busy
    load_map(2);
    d0 = done_cnt;
    start_frame("B");
    fork
      recv_frame(2, 330, "B");
      begin
        load_map(1);
        wait (byte_idx == 100);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    finish_frame(d0, "B", 1'b0);

    // frame C: bright map, then frozen, then out-of-range pixels that would alias
    load_map(1);
    capture_en = 1'b0;
    load_map(0);
    capture_en = 1'b1;
    poke(160, 0, 16'h0000);
    poke(168, 8, 16'h0000);
    d0 = done_cnt;
    start_frame("C");
    recv_frame(1, 330, "C");
    finish_frame(d0, "C", 1'b1);

    // frame D chained on C's done; reset lands in byte 50's data bits
    recv_frame(1, 50, "D");
    found = 1'b0;
    idle = 0;
    while (!found && idle <= 3) begin
      @(negedge clk);
      if (tx === 1'b0) found = 1'b1;
      else idle++;
    end
    check(found, "D50 start gap", 64'(idle), 3);
    repeat (12) @(negedge clk);
    check(tx === 1'b0, "D50 data bit2 low", 64'(tx), 0);
    reset = 1'b0;
    #1;
    check(tx === 1'b1, "midbyte reset tx", 64'(tx), 1);
    check(busy === 1'b0, "midbyte reset busy", 64'(busy), 0);
    check(done === 1'b0, "midbyte reset done", 64'(done), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
      if (busy !== 1'b0) lows++;
    end
    check(lows == 0, "no resume after reset", 64'(lows), 0);

    // frame E restarts from row 0 col 0; map survived reset
    start_frame("E");
    recv_frame(1, 25, "E");

    reset = 1'b0;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
